ftsd_scan_sched: RTL

- Time-base and update scheduler for the 4-digit 14-segment scan multiplexer.
- Generates the 2-bit digit-select sequence with an anti-ghosting blanking window at the start of each digit slot.
- Holds the four displayed digit codes in registers. Accepts new digit sets from a producer through a req/ack handshake and commits them only at a frame boundary, so no frame is ever torn.
- Sits between the application logic and the scan mux / segment decoder.

---
 rtl/ftsd_scan_sched.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/ftsd_scan_sched.sv
// Scan time base and frame-synchronous digit update scheduler for the
// 4-digit 14-segment display. Slot counter drives the digit select and the
// anti-ghosting blank window; new digit sets arrive over a req/ack
// handshake and are committed only on the last cycle of slot 3.
module ftsd_scan_sched #(
    parameter int unsigned DW        = 4,
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLANK_CYC = 500,
    parameter int unsigned CW        = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          upd_req,
    input  logic [DW-1:0] upd_d0,
    input  logic [DW-1:0] upd_d1,
    input  logic [DW-1:0] upd_d2,
    input  logic [DW-1:0] upd_d3,
    output logic          upd_busy,
    output logic          upd_ack,
    output logic [DW-1:0] dig0,
    output logic [DW-1:0] dig1,
    output logic [DW-1:0] dig2,
    output logic [DW-1:0] dig3,
    output logic [1:0]    ftsd_ctl_en,
    output logic          blank,
    output logic          frame_tick
);

    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } hs_state_t;

    hs_state_t                state, state_nxt;
    logic [CW-1:0]            cnt, cnt_nxt;
    logic [1:0]               ctl_nxt;
    logic                     commit;
    logic                     in_blank_win;
    logic                     blank_nxt;
    logic                     tick_nxt;
    logic [3:0][DW-1:0]       upd_in;
    logic [3:0][DW-1:0]       pend_q, pend_nxt;
    logic [3:0][DW-1:0]       dig_q, dig_nxt;
    logic                     busy_nxt;
    logic                     ack_nxt;

    assign upd_in = {upd_d3, upd_d2, upd_d1, upd_d0};

    assign dig0 = dig_q[0];
    assign dig1 = dig_q[1];
    assign dig2 = dig_q[2];
    assign dig3 = dig_q[3];

    // Last cycle of slot 3 with scanning active: the only point where digits change
    assign commit = en && (cnt == CNT_LAST) && (ftsd_ctl_en == 2'd3);

    // Slot counter and digit select advance; both freeze while en is low
    always_comb begin
        cnt_nxt = cnt;
        ctl_nxt = ftsd_ctl_en;
        if (en) begin
            if (cnt == CNT_LAST) begin
                cnt_nxt = '0;
                ctl_nxt = ftsd_ctl_en + 2'd1;
            end else begin
                cnt_nxt = cnt + CW'(1);
            end
        end
    end

    // A zero-length blank window needs no comparator at all
    generate
        if (BLANK_CYC == 0) begin : g_no_blank
            assign in_blank_win = 1'b0;
        end else begin : g_blank
            assign in_blank_win = (cnt_nxt < CW'(BLANK_CYC));
        end
    endgenerate

    // Blank and frame tick are computed from the upcoming counter state so the
    // registered versions line up with the cycle they describe
    always_comb begin
        blank_nxt = !en || in_blank_win;
        tick_nxt  = en && (cnt_nxt == CNT_LAST) && (ctl_nxt == 2'd3);
    end

    // Handshake next-state: capture on every request, commit at the frame boundary
    always_comb begin
        state_nxt = state;
        pend_nxt  = pend_q;
        dig_nxt   = dig_q;
        ack_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (upd_req) begin
                    pend_nxt  = upd_in;
                    state_nxt = PEND;
                end
            end
            PEND: begin
                if (commit) begin
                    dig_nxt   = pend_q;
                    ack_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
                if (upd_req) begin
                    pend_nxt  = upd_in;
                    state_nxt = PEND;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        busy_nxt = (state_nxt == PEND);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            ftsd_ctl_en <= 2'd0;
            blank       <= 1'b1;
            frame_tick  <= 1'b0;
            pend_q      <= '0;
            dig_q       <= '0;
            upd_busy    <= 1'b0;
            upd_ack     <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            ftsd_ctl_en <= ctl_nxt;
            blank       <= blank_nxt;
            frame_tick  <= tick_nxt;
            pend_q      <= pend_nxt;
            dig_q       <= dig_nxt;
            upd_busy    <= busy_nxt;
            upd_ack     <= ack_nxt;
        end
    end

endmodule
